// File: rtl/bus_pkg.sv
// Shared constants and FSM encoding for the SRAM bus slave.
// Imported by bus_sram_slave and sram_be_1rw.
package bus_pkg;

  localparam int BUS_DATA_W = 32;
  localparam int BURST_W    = 8;
  localparam int BE_W       = BUS_DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERROR,
    ST_READ_WAIT,
    ST_READ_BURST,
    ST_READ_END,
    ST_WRITE
  } state_t;

endpackage

// File: rtl/sram_be_1rw.sv
// Single-port synchronous RAM, per-byte write enables, 1-cycle read.
// Ports: clock, en, we[BE_W], addr, wdata -> rdata (registered).
module sram_be_1rw
  import bus_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic [BE_W-1:0]       we,
  input  logic [AW-1:0]         addr,
  input  logic [BUS_DATA_W-1:0] wdata,
  output logic [BUS_DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [BUS_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (we[i]) begin
          mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bus_sram_slave.sv
// SRAM bus slave: single/burst reads and writes on a shared bus.
// Ports: clock, reset, bus request inputs -> OR-able response outputs.
module bus_sram_slave
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS    = 32'h5000_0000,
  parameter int          ADDR_WORDS_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  beginTransactionIn,
  input  logic [BUS_DATA_W-1:0] addressDataIn,
  input  logic [BURST_W-1:0]    burstSizeIn,
  input  logic                  readNotWriteIn,
  input  logic [BE_W-1:0]       byteEnablesIn,
  input  logic                  dataValidIn,
  input  logic                  endTransactionIn,
  output logic [BUS_DATA_W-1:0] addressDataOut,
  output logic                  dataValidOut,
  output logic                  endTransactionOut,
  output logic                  busErrorOut
);

  localparam int AW    = ADDR_WORDS_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam int SW    = ((AW > BURST_W) ? AW : BURST_W) + 1;
  localparam logic [AW-1:0] IDX_ONE = 'd1;

  state_t state;
  state_t state_nx;

  logic [AW-1:0]    idx;
  logic [AW-1:0]    idx_nx;
  logic [8:0]       cnt;
  logic [8:0]       cnt_nx;
  logic [BE_W-1:0]  be;
  logic [BE_W-1:0]  be_nx;

  logic                  ram_en;
  logic [BE_W-1:0]       ram_we;
  logic [BUS_DATA_W-1:0] ram_rdata;

  logic          sel;
  logic [AW-1:0] req_idx;
  logic [SW-1:0] span;
  logic          range_err;
  logic          unused_lsb;

  assign sel = beginTransactionIn &&
    (addressDataIn[31:AW+2] == BASE_ADDRESS[31:AW+2]);
  assign req_idx    = addressDataIn[AW+1:2];
  assign span       = SW'(req_idx) + SW'(burstSizeIn);
  assign range_err  = span > SW'(DEPTH - 1);
  assign unused_lsb = ^addressDataIn[1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
      be    <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
      be    <= be_nx;
    end
  end

  // Read counter holds beats still to issue after the current one;
  // write counter holds beats still accepted.
  always_comb begin
    state_nx          = state;
    idx_nx            = idx;
    cnt_nx            = cnt;
    be_nx             = be;
    ram_en            = 1'b0;
    ram_we            = '0;
    addressDataOut    = '0;
    dataValidOut      = 1'b0;
    endTransactionOut = 1'b0;
    busErrorOut       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (sel) begin
          idx_nx = req_idx;
          be_nx  = byteEnablesIn;
          if (range_err) begin
            state_nx = ST_ERROR;
          end else if (readNotWriteIn) begin
            state_nx = ST_READ_WAIT;
            cnt_nx   = {1'b0, burstSizeIn};
          end else begin
            state_nx = ST_WRITE;
            cnt_nx   = {1'b0, burstSizeIn} + 9'd1;
          end
        end
      end
      ST_ERROR: begin
        busErrorOut       = 1'b1;
        endTransactionOut = 1'b1;
        state_nx          = ST_IDLE;
      end
      ST_READ_WAIT: begin
        ram_en   = 1'b1;
        idx_nx   = idx + IDX_ONE;
        state_nx = ST_READ_BURST;
      end
      ST_READ_BURST: begin
        dataValidOut   = 1'b1;
        addressDataOut = ram_rdata;
        if (cnt == 9'd0) begin
          state_nx = ST_READ_END;
        end else begin
          ram_en = 1'b1;
          idx_nx = idx + IDX_ONE;
          cnt_nx = cnt - 9'd1;
        end
      end
      ST_READ_END: begin
        endTransactionOut = 1'b1;
        state_nx          = ST_IDLE;
      end
      ST_WRITE: begin
        if (dataValidIn && cnt != 9'd0) begin
          ram_en = 1'b1;
          ram_we = be;
          idx_nx = idx + IDX_ONE;
          cnt_nx = cnt - 9'd1;
        end
        if (endTransactionIn) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // A write beat coinciding with the reset edge must not land.
  sram_be_1rw #(
    .AW(AW)
  ) u_ram (
    .clock(clock),
    .en   (ram_en && !reset),
    .we   (reset ? '0 : ram_we),
    .addr (idx),
    .wdata(addressDataIn),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_bus_sram_slave.sv
// Directed bench for bus_sram_slave.
// Drives on falling edges, samples outputs on falling edges.
module tb_bus_sram_slave;

  localparam logic [31:0] BASE = 32'h5000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        beginTransactionIn;
  logic [31:0] addressDataIn;
  logic [7:0]  burstSizeIn;
  logic        readNotWriteIn;
  logic [3:0]  byteEnablesIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busErrorOut;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] ob_data [32];
  logic        ob_dv   [32];
  logic        ob_end  [32];
  logic        ob_err  [32];
  logic [31:0] wbuf    [8];
  logic        wr_end_seen;

  always #5 clock = ~clock;

  bus_sram_slave #(
    .BASE_ADDRESS   (BASE),
    .ADDR_WORDS_LOG2(10)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .beginTransactionIn(beginTransactionIn),
    .addressDataIn    (addressDataIn),
    .burstSizeIn      (burstSizeIn),
    .readNotWriteIn   (readNotWriteIn),
    .byteEnablesIn    (byteEnablesIn),
    .dataValidIn      (dataValidIn),
    .endTransactionIn (endTransactionIn),
    .addressDataOut   (addressDataOut),
    .dataValidOut     (dataValidOut),
    .endTransactionOut(endTransactionOut),
    .busErrorOut      (busErrorOut)
  );

  task automatic idle_inputs();
    beginTransactionIn = 1'b0;
    addressDataIn      = '0;
    burstSizeIn        = '0;
    readNotWriteIn     = 1'b0;
    byteEnablesIn      = '0;
    dataValidIn        = 1'b0;
    endTransactionIn   = 1'b0;
  endtask

  // Begin at edge T; ob[i] holds outputs of cycle T+i.
  // xat: extra begin driven after sample i; rat: reset after sample i.
  task automatic cap(input logic [31:0] a, input logic [7:0] b,
                     input logic rnw, input int n, input int xat,
                     input logic [31:0] xaddr, input int rat);
    @(negedge clock);
    beginTransactionIn = 1'b1;
    addressDataIn      = a;
    burstSizeIn        = b;
    readNotWriteIn     = rnw;
    byteEnablesIn      = 4'hF;
    for (int i = 1; i <= n; i++) begin
      @(negedge clock);
      ob_data[i] = addressDataOut;
      ob_dv[i]   = dataValidOut;
      ob_end[i]  = endTransactionOut;
      ob_err[i]  = busErrorOut;
      idle_inputs();
      reset = 1'b0;
      if (i == xat) begin
        beginTransactionIn = 1'b1;
        addressDataIn      = xaddr;
        burstSizeIn        = 8'd0;
        readNotWriteIn     = 1'b1;
      end
      if (i == rat) reset = 1'b1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] b,
                           input logic [3:0] be, input int nb);
    wr_end_seen = 1'b0;
    @(negedge clock);
    beginTransactionIn = 1'b1;
    addressDataIn      = a;
    burstSizeIn        = b;
    readNotWriteIn     = 1'b0;
    byteEnablesIn      = be;
    for (int i = 0; i < nb; i++) begin
      @(negedge clock);
      wr_end_seen        = wr_end_seen | endTransactionOut;
      beginTransactionIn = 1'b0;
      dataValidIn        = 1'b1;
      addressDataIn      = wbuf[i];
      endTransactionIn   = (i == nb - 1);
    end
    @(negedge clock);
    wr_end_seen = wr_end_seen | endTransactionOut;
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clock);
    compared += 4;
    if (addressDataOut !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_data got=%h exp=0", addressDataOut);
    end
    if (dataValidOut !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_dv got=%b exp=0", dataValidOut);
    end
    if (endTransactionOut !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_end got=%b exp=0", endTransactionOut);
    end
    if (busErrorOut !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_err got=%b exp=0", busErrorOut);
    end
    reset = 1'b0;
  endtask

  task automatic preload();
    wbuf[0] = 32'hDEADBEEF;
    bus_write(BASE + 32'h14, 8'd0, 4'hF, 1);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    bus_write(BASE + 32'h40, 8'd3, 4'hF, 4);
    for (int i = 0; i < 3; i++) wbuf[i] = 32'hFFFF_FFFF;
    bus_write(BASE + 32'h100, 8'd2, 4'hF, 3);
    wbuf[0] = 32'h0;
    wbuf[1] = 32'h0;
    bus_write(BASE + 32'h118, 8'd1, 4'hF, 2);
    wbuf[0] = 32'hA5A5_A5A5;
    bus_write(BASE + 32'hFFC, 8'd0, 4'hF, 1);
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h1000 + 32'(i);
    bus_write(BASE + 32'h80, 8'd7, 4'hF, 8);
  endtask

  task automatic test_single_read();
    logic [31:0] ed;
    cap(BASE + 32'h14, 8'd0, 1'b1, 5, 0, 32'h0, 0);
    for (int i = 1; i <= 5; i++) begin
      ed = (i == 2) ? 32'hDEADBEEF : 32'h0;
      compared += 3;
      if (ob_dv[i] !== (i == 2)) begin
        mismatched++;
        $display("FAIL single_dv c%0d got=%b", i, ob_dv[i]);
      end
      if (ob_data[i] !== ed) begin
        mismatched++;
        $display("FAIL single_data c%0d got=%h exp=%h", i, ob_data[i], ed);
      end
      if (ob_end[i] !== (i == 3)) begin
        mismatched++;
        $display("FAIL single_end c%0d got=%b", i, ob_end[i]);
      end
    end
  endtask

  task automatic test_burst_read();
    logic [31:0] ed;
    cap(BASE + 32'h40, 8'd3, 1'b1, 7, 0, 32'h0, 0);
    for (int i = 1; i <= 7; i++) begin
      ed = (i >= 2 && i <= 5) ? 32'(i - 1) : 32'h0;
      compared += 3;
      if (ob_dv[i] !== (i >= 2 && i <= 5)) begin
        mismatched++;
        $display("FAIL burst_dv c%0d got=%b", i, ob_dv[i]);
      end
      if (ob_data[i] !== ed) begin
        mismatched++;
        $display("FAIL burst_data c%0d got=%h exp=%h", i, ob_data[i], ed);
      end
      if (ob_end[i] !== (i == 6)) begin
        mismatched++;
        $display("FAIL burst_end c%0d got=%b", i, ob_end[i]);
      end
    end
  endtask

  task automatic test_write_be();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'hFFFF2222;
    exp_w[1] = 32'hFFFF4444;
    exp_w[2] = 32'hFFFF6666;
    wbuf[0] = 32'h11112222;
    wbuf[1] = 32'h33334444;
    wbuf[2] = 32'h55556666;
    bus_write(BASE + 32'h100, 8'd2, 4'b0011, 3);
    compared++;
    if (wr_end_seen !== 1'b0) begin
      mismatched++;
      $display("FAIL write_end_out got=%b exp=0", wr_end_seen);
    end
    cap(BASE + 32'h100, 8'd2, 1'b1, 6, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (ob_data[i+2] !== exp_w[i] || ob_dv[i+2] !== 1'b1) begin
        mismatched++;
        $display("FAIL be_word%0d got=%h exp=%h", 64 + i, ob_data[i+2], exp_w[i]);
      end
    end
    // Second beat exceeds a single-word burst and must be dropped.
    wbuf[0] = 32'hAAAA0001;
    wbuf[1] = 32'hAAAA0002;
    bus_write(BASE + 32'h118, 8'd0, 4'hF, 2);
    cap(BASE + 32'h118, 8'd1, 1'b1, 5, 0, 32'h0, 0);
    compared += 2;
    if (ob_data[2] !== 32'hAAAA0001) begin
      mismatched++;
      $display("FAIL drop_w70 got=%h exp=aaaa0001", ob_data[2]);
    end
    if (ob_data[3] !== 32'h0 || ob_dv[3] !== 1'b1) begin
      mismatched++;
      $display("FAIL drop_w71 got=%h exp=0", ob_data[3]);
    end
  endtask

  task automatic test_range_error();
    cap(BASE + 32'hFFC, 8'd1, 1'b1, 4, 0, 32'h0, 0);
    for (int i = 1; i <= 4; i++) begin
      compared += 3;
      if (ob_err[i] !== (i == 1)) begin
        mismatched++;
        $display("FAIL err_bus c%0d got=%b", i, ob_err[i]);
      end
      if (ob_end[i] !== (i == 1)) begin
        mismatched++;
        $display("FAIL err_end c%0d got=%b", i, ob_end[i]);
      end
      if (ob_dv[i] !== 1'b0 || ob_data[i] !== 32'h0) begin
        mismatched++;
        $display("FAIL err_dv c%0d got=%b/%h", i, ob_dv[i], ob_data[i]);
      end
    end
    wbuf[0] = 32'h12345678;
    wbuf[1] = 32'h9ABCDEF0;
    bus_write(BASE + 32'hFFC, 8'd1, 4'hF, 2);
    cap(BASE + 32'hFFC, 8'd0, 1'b1, 4, 0, 32'h0, 0);
    compared += 2;
    if (ob_data[2] !== 32'hA5A5A5A5 || ob_dv[2] !== 1'b1) begin
      mismatched++;
      $display("FAIL err_mem got=%h exp=a5a5a5a5", ob_data[2]);
    end
    if (ob_end[3] !== 1'b1 || ob_err[1] !== 1'b0) begin
      mismatched++;
      $display("FAIL last_word_end got=%b err=%b", ob_end[3], ob_err[1]);
    end
  endtask

  task automatic test_decode_busy();
    logic [31:0] ed;
    cap(BASE + 32'h1000, 8'd0, 1'b1, 5, 0, 32'h0, 0);
    for (int i = 1; i <= 5; i++) begin
      compared++;
      if ({ob_dv[i], ob_end[i], ob_err[i]} !== 3'b000 || ob_data[i] !== 32'h0) begin
        mismatched++;
        $display("FAIL decode c%0d got=%b%b%b/%h exp=0", i,
                 ob_dv[i], ob_end[i], ob_err[i], ob_data[i]);
      end
    end
    cap(BASE + 32'h40, 8'd3, 1'b1, 9, 3, BASE + 32'h14, 0);
    for (int i = 1; i <= 9; i++) begin
      ed = (i >= 2 && i <= 5) ? 32'(i - 1) : 32'h0;
      compared++;
      if (ob_data[i] !== ed || ob_dv[i] !== (i >= 2 && i <= 5) ||
          ob_end[i] !== (i == 6)) begin
        mismatched++;
        $display("FAIL busy c%0d got=%b/%b/%h exp=%h", i,
                 ob_dv[i], ob_end[i], ob_data[i], ed);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    cap(BASE + 32'h80, 8'd7, 1'b1, 12, 0, 32'h0, 4);
    for (int i = 2; i <= 4; i++) begin
      compared++;
      if (ob_data[i] !== 32'h1000 + 32'(i - 2) || ob_dv[i] !== 1'b1) begin
        mismatched++;
        $display("FAIL rst_beat c%0d got=%h", i, ob_data[i]);
      end
    end
    for (int i = 5; i <= 12; i++) begin
      compared++;
      if ({ob_dv[i], ob_end[i], ob_err[i]} !== 3'b000 || ob_data[i] !== 32'h0) begin
        mismatched++;
        $display("FAIL rst_quiet c%0d got=%b%b%b/%h exp=0", i,
                 ob_dv[i], ob_end[i], ob_err[i], ob_data[i]);
      end
    end
    cap(BASE + 32'h84, 8'd1, 1'b1, 5, 0, 32'h0, 0);
    compared += 3;
    if (ob_data[2] !== 32'h1001) begin
      mismatched++;
      $display("FAIL rst_after0 got=%h exp=00001001", ob_data[2]);
    end
    if (ob_data[3] !== 32'h1002) begin
      mismatched++;
      $display("FAIL rst_after1 got=%h exp=00001002", ob_data[3]);
    end
    if (ob_end[4] !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_after_end got=%b exp=1", ob_end[4]);
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_single_read();
    test_burst_read();
    test_write_be();
    test_range_error();
    test_decode_busy();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
